data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 256, giving the storage size in 32-bit words (power of two, minimum 4).
REQ-002 SHALL have parameter WAIT_STATES, default 2, giving added response latency in cycles (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_i, input, 1 bit: initiator request, held high until ack_o.
REQ-006 SHALL have port we_i, input, 1 bit: 1 = store, 0 = load; valid with req_i.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address; valid with req_i.
REQ-008 SHALL have port wdata_i, input, 32 bits: store data; valid with req_i.
REQ-009 SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rdata_o, output, 32 bits: registered load data; valid while ack_o=1 for a load.
REQ-011 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port err_o, output, 1 bit: address-error flag, qualified by ack_o.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE with req_i=1, SHALL accept the request: capture we_i, addr_i and wdata_i, and load the latency counter with WAIT_STATES.
REQ-015 On acceptance, SHALL go to WAIT if WAIT_STATES>0, else to RESP.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-017 ack_o SHALL be high only in RESP, for exactly one cycle, first seen after acceptance edge + WAIT_STATES edges.
REQ-018 RESP SHALL return unconditionally to IDLE.
REQ-019 req_i sampled while in RESP SHALL be ignored, giving a minimum request spacing of WAIT_STATES+2 cycles.
REQ-020 The word index SHALL be addr[log2(MEMORY_DEPTH)+1:2].
REQ-021 A store SHALL commit to the array on the edge entering RESP.
REQ-022 A load SHALL register the array word into rdata_o on that same edge.
REQ-023 rdata_o SHALL hold its value across store responses and idle cycles.
REQ-024 Captured request fields SHALL be used for the whole transaction; input changes after acceptance SHALL have no effect.
REQ-025 The array SHALL read combinationally and write synchronously.

Reset
REQ-026 While reset=0, SHALL force state IDLE, ack_o=0, busy_o=0, err_o=0, rdata_o=0 and counter=0, asynchronously.
REQ-027 Reset asserted mid-transaction SHALL abort it; an uncommitted store SHALL never be written, and no ack_o SHALL follow.
REQ-028 Array contents SHALL NOT be reset.

Configuration
REQ-029 With MEM_ADDR_CHECK_EN defined, addr[1:0]!=0 or addr>=4*MEMORY_DEPTH SHALL cause err_o=1 with ack_o, suppress the store write, and leave rdata_o unchanged.
REQ-030 Without MEM_ADDR_CHECK_EN, err_o SHALL be constant 0, and out-of-range addresses SHALL wrap modulo MEMORY_DEPTH with addr[1:0] ignored.

Verification
REQ-031 WAIT_STATES=2: store 0xDEADBEEF at 0x10, then load 0x10 -> each ack_o is a single pulse 3 cycles after its acceptance edge; load rdata_o=0xDEADBEEF.
REQ-032 WAIT_STATES=0: load immediately after a store to 0x04 -> ack_o on the cycle following acceptance; data matches; busy_o high for 1 cycle per transaction.
REQ-033 Change addr_i and wdata_i to 0x20 and 0x12345678 during WAIT of a store to 0x08 -> 0x08 gets the original data; 0x20 is unchanged.
REQ-034 Assert reset during WAIT of a store of 0xA5A5A5A5 to 0x0C -> no ack_o; a later load of 0x0C returns the prior value.
REQ-035 MEM_ADDR_CHECK_EN defined: store to 0x402 (MEMORY_DEPTH=256) -> ack_o with err_o=1 and memory unchanged. Macro undefined: store to 0x400 -> aliases to word 0, read back at 0x000.
REQ-036 req_i held high across two transactions -> second acceptance occurs only after the RESP cycle; ack_o pulses are separated by WAIT_STATES+2 cycles.

Source files
------------

// File: rtl/data_memory_responder.sv
// Wait-stated single-port word memory behind a req/ack handshake.
// Define MEM_ADDR_CHECK_EN to flag misaligned/out-of-range addresses on err_o.
module data_memory_responder #(
    parameter int unsigned MEMORY_DEPTH = 256,
    parameter int unsigned WAIT_STATES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int unsigned AW = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            bad_q;
    logic [31:0]     mem [MEMORY_DEPTH];

    logic            accept;
    logic            enter_resp;
    logic            in_bad;
    logic            cur_we;
    logic            cur_bad;
    logic [AW-1:0]   cur_idx;
    logic [31:0]     cur_wdata;

`ifdef MEM_ADDR_CHECK_EN
    assign in_bad = (addr_i[1:0] != 2'b00) || (addr_i[31:AW+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};
    assign in_bad = 1'b0;
    assign err_o  = 1'b0;
`endif

    assign accept = (state_q == StIdle) && req_i;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-captured fields.
    assign cur_we    = accept ? we_i              : we_q;
    assign cur_idx   = accept ? addr_i[AW+1:2]    : idx_q;
    assign cur_wdata = accept ? wdata_i           : wdata_q;
    assign cur_bad   = accept ? in_bad            : bad_q;

    assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                        ((state_q == StWait) && (cnt_q == 4'd1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_i) state_d = (WAIT_STATES == 0) ? StResp : StWait;
            StWait:  if (cnt_q == 4'd1) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            bad_q   <= 1'b0;
            ack_o   <= 1'b0;
            busy_o  <= 1'b0;
            rdata_o <= 32'd0;
`ifdef MEM_ADDR_CHECK_EN
            err_o   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != StIdle);
            ack_o   <= enter_resp;
`ifdef MEM_ADDR_CHECK_EN
            err_o   <= enter_resp && cur_bad;
`endif
            if (enter_resp && !cur_we && !cur_bad) begin
                rdata_o <= mem[cur_idx];
            end
            if (accept) begin
                we_q    <= we_i;
                idx_q   <= addr_i[AW+1:2];
                wdata_q <= wdata_i;
                bad_q   <= in_bad;
                cnt_q   <= 4'(WAIT_STATES);
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_bad) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 and 0 wait states) checked
// against a shadow memory through per-instance expected-response queues.
module tb_data_memory_responder;
    localparam int DEPTH = 256;
    localparam int WS0   = 2;
    localparam int WS1   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, busy0, err0, ack1, busy1, err1;
    logic [31:0] rdata0, rdata1;

    data_memory_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .reset(reset), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wdata_i(wdata0), .ack_o(ack0), .rdata_o(rdata0), .busy_o(busy0), .err_o(err0)
    );

    data_memory_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(reset), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .ack_o(ack1), .rdata_o(rdata1), .busy_o(busy1), .err_o(err1)
    );

    typedef struct {
        int          exp_cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    exp_t        mon_e;
    logic [31:0] model0 [DEPTH];
    logic [31:0] model1 [DEPTH];
    logic [31:0] last0, last1;
    int          cyc     = 0;
    int          n_check = 0;
    int          n_pass  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic void push_exp(input int d, input logic we, input logic [31:0] a,
                                     input logic [31:0] wd, input int exp_cyc);
        exp_t       e;
        logic [7:0] idx = a[9:2];
        logic       bad = addr_bad(a);
        if (d == 0) begin
            if (!bad) begin
                if (we) model0[idx] = wd;
                else    last0 = model0[idx];
            end
            e.rdata = last0;
        end else begin
            if (!bad) begin
                if (we) model1[idx] = wd;
                else    last1 = model1[idx];
            end
            e.rdata = last1;
        end
        e.exp_cyc = exp_cyc;
        e.err     = bad;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    task automatic set_in(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd);
        if (d == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = wd;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = wd;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the ack.
    task automatic drive_txn(input int d, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic mut, input logic [31:0] ma,
                             input logic [31:0] mwd, output int busy_cnt);
        int ws  = (d == 0) ? WS0 : WS1;
        bit got = 0;
        push_exp(d, we, a, wd, cyc + 1 + ws);
        set_in(d, 1'b1, we, a, wd);
        busy_cnt = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (mut && t == 0) set_in(d, 1'b1, we, ma, mwd);
            if (get_busy(d)) busy_cnt++;
            if (get_ack(d)) got = 1;
        end
        set_in(d, 1'b0, 1'b0, 32'h0, 32'h0);
        n_check++;
        if (!got) $display("FAIL ack_timeout d%0d: ack=0 after 40 cycles, required 1", d);
        else      n_pass++;
        @(negedge clk);
    endtask

    // Scoreboard: every ack pops one expected response.
    always @(negedge clk) begin
        if (reset) begin
            if (ack0) begin
                n_check++;
                if (sb0.size() == 0) begin
                    $display("FAIL spurious_ack d0 cycle %0d: ack=1, required 0", cyc);
                end else begin
                    n_pass++;
                    mon_e = sb0.pop_front();
                    n_check += 3;
                    if (cyc !== mon_e.exp_cyc)
                        $display("FAIL ack_cycle d0: got %0d, required %0d", cyc, mon_e.exp_cyc);
                    else n_pass++;
                    if (rdata0 !== mon_e.rdata)
                        $display("FAIL rdata d0: got %h, required %h", rdata0, mon_e.rdata);
                    else n_pass++;
                    if (err0 !== mon_e.err)
                        $display("FAIL err d0: got %b, required %b", err0, mon_e.err);
                    else n_pass++;
                end
            end
            if (ack1) begin
                n_check++;
                if (sb1.size() == 0) begin
                    $display("FAIL spurious_ack d1 cycle %0d: ack=1, required 0", cyc);
                end else begin
                    n_pass++;
                    mon_e = sb1.pop_front();
                    n_check += 3;
                    if (cyc !== mon_e.exp_cyc)
                        $display("FAIL ack_cycle d1: got %0d, required %0d", cyc, mon_e.exp_cyc);
                    else n_pass++;
                    if (rdata1 !== mon_e.rdata)
                        $display("FAIL rdata d1: got %h, required %h", rdata1, mon_e.rdata);
                    else n_pass++;
                    if (err1 !== mon_e.err)
                        $display("FAIL err d1: got %b, required %b", err1, mon_e.err);
                    else n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
        last0 = 32'h0;
        last1 = 32'h0;
        repeat (2) @(negedge clk);
        n_check += 8;
        if (ack0 !== 1'b0)    $display("FAIL reset_ack0: got %b, required 0", ack0);    else n_pass++;
        if (busy0 !== 1'b0)   $display("FAIL reset_busy0: got %b, required 0", busy0);  else n_pass++;
        if (err0 !== 1'b0)    $display("FAIL reset_err0: got %b, required 0", err0);    else n_pass++;
        if (rdata0 !== 32'h0) $display("FAIL reset_rdata0: got %h, required 0", rdata0); else n_pass++;
        if (ack1 !== 1'b0)    $display("FAIL reset_ack1: got %b, required 0", ack1);    else n_pass++;
        if (busy1 !== 1'b0)   $display("FAIL reset_busy1: got %b, required 0", busy1);  else n_pass++;
        if (err1 !== 1'b0)    $display("FAIL reset_err1: got %b, required 0", err1);    else n_pass++;
        if (rdata1 !== 32'h0) $display("FAIL reset_rdata1: got %h, required 0", rdata1); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load_ws2();
        int bc;
        drive_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, bc);
        n_check += 2;
        if (bc !== WS0 + 1) $display("FAIL ws2_busy_store: got %0d, required %0d", bc, WS0 + 1);
        else n_pass++;
        if (busy0 !== 1'b0) $display("FAIL ws2_busy_idle: got %b, required 0", busy0);
        else n_pass++;
        drive_txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, bc);
        n_check++;
        if (rdata0 !== 32'hDEADBEEF) $display("FAIL ws2_rdata_hold: got %h, required deadbeef", rdata0);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        int bc;
        drive_txn(1, 1'b1, 32'h04, 32'h13579BDF, 1'b0, 32'h0, 32'h0, bc);
        n_check++;
        if (bc !== 1) $display("FAIL ws0_busy_store: got %0d, required 1", bc); else n_pass++;
        drive_txn(1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 32'h0, bc);
        n_check += 2;
        if (bc !== 1) $display("FAIL ws0_busy_load: got %0d, required 1", bc); else n_pass++;
        if (busy1 !== 1'b0) $display("FAIL ws0_busy_idle: got %b, required 0", busy1); else n_pass++;
    endtask

    task automatic test_hold_inputs();
        int bc;
        drive_txn(0, 1'b1, 32'h20, 32'h20202020, 1'b0, 32'h0, 32'h0, bc);
        drive_txn(0, 1'b1, 32'h08, 32'h0BADF00D, 1'b1, 32'h20, 32'h12345678, bc);
        drive_txn(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 32'h0, bc);
        drive_txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, bc);
    endtask

    task automatic test_reset_abort();
        int bc;
        drive_txn(0, 1'b1, 32'h0C, 32'h11111111, 1'b0, 32'h0, 32'h0, bc);
        set_in(0, 1'b1, 1'b1, 32'h0C, 32'hA5A5A5A5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_check += 3;
        if (busy0 !== 1'b0)   $display("FAIL abort_busy: got %b, required 0", busy0);    else n_pass++;
        if (ack0 !== 1'b0)    $display("FAIL abort_ack: got %b, required 0", ack0);      else n_pass++;
        if (rdata0 !== 32'h0) $display("FAIL abort_rdata: got %h, required 0", rdata0); else n_pass++;
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        last0 = 32'h0;
        last1 = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        drive_txn(0, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0, 32'h0, bc);
    endtask

    task automatic test_addr_map();
        int bc;
`ifdef MEM_ADDR_CHECK_EN
        drive_txn(0, 1'b1, 32'h000, 32'h0000AAAA, 1'b0, 32'h0, 32'h0, bc);
        drive_txn(0, 1'b1, 32'h402, 32'hBAD0BAD0, 1'b0, 32'h0, 32'h0, bc);
        drive_txn(0, 1'b0, 32'h402, 32'h0, 1'b0, 32'h0, 32'h0, bc);
        drive_txn(0, 1'b0, 32'h000, 32'h0, 1'b0, 32'h0, 32'h0, bc);
`else
        drive_txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, bc);
        drive_txn(0, 1'b0, 32'h000, 32'h0, 1'b0, 32'h0, 32'h0, bc);
        drive_txn(1, 1'b1, 32'h7FC, 32'h600DCAFE, 1'b0, 32'h0, 32'h0, bc);
        drive_txn(1, 1'b0, 32'h3FF, 32'h0, 1'b0, 32'h0, 32'h0, bc);
`endif
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            int ws = (d == 0) ? WS0 : WS1;
            int a1 = -1;
            int a2 = -1;
            push_exp(d, 1'b1, 32'h30, 32'h0F0F0F0F + d, cyc + 1 + ws);
            push_exp(d, 1'b0, 32'h30, 32'h0, cyc + 1 + ws + ws + 2);
            set_in(d, 1'b1, 1'b1, 32'h30, 32'h0F0F0F0F + d);
            for (int t = 0; t < 40 && a2 < 0; t++) begin
                @(negedge clk);
                if (get_ack(d)) begin
                    if (a1 < 0) begin
                        a1 = cyc;
                        set_in(d, 1'b1, 1'b0, 32'h30, 32'h0);
                    end else begin
                        a2 = cyc;
                    end
                end
            end
            set_in(d, 1'b0, 1'b0, 32'h0, 32'h0);
            n_check++;
            if (a1 < 0 || a2 < 0 || (a2 - a1) != ws + 2)
                $display("FAIL b2b_spacing d%0d: got %0d, required %0d", d, a2 - a1, ws + 2);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int          bc;
        logic [31:0] a, v;
        for (int i = 0; i < 6; i++) begin
            a = {22'h0, 8'($urandom_range(64, 255)), 2'b00};
            v = $urandom;
            drive_txn(i % 2, 1'b1, a, v, 1'b0, 32'h0, 32'h0, bc);
            drive_txn(i % 2, 1'b0, a, 32'h0, 1'b0, 32'h0, 32'h0, bc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load_ws2();
        test_zero_wait();
        test_hold_inputs();
        test_reset_abort();
        test_addr_map();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge clk);
        n_check += 2;
        if (sb0.size() != 0) $display("FAIL pending_d0: got %0d left, required 0", sb0.size());
        else n_pass++;
        if (sb1.size() != 0) $display("FAIL pending_d1: got %0d left, required 0", sb1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
